// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: captures bytes on the falling edge of the active-low IOload strobe,
// buffers them in a FIFO and sends them as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       io_load,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]      BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]      BAUD_ONE = BW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Write capture: the event is registered together with its data, so the
  // FIFO push lands one edge after the sampling edge.
  logic       ld_q, wr_vld;
  logic [7:0] wr_byte;

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      ld_q    <= 1'b1;
      wr_vld  <= 1'b0;
      wr_byte <= '0;
    end else begin
      ld_q   <= io_load;
      wr_vld <= ld_q & ~io_load;
      if (ld_q & ~io_load) wr_byte <= wr_data;
    end
  end

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic               pop, push_ok;

  // count never exceeds DEPTH, so its MSB alone marks a full FIFO
  assign push_ok = wr_vld & (~count[FIFO_AW] | pop);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wptr] <= wr_byte;
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      count    <= count_nxt;
      tx_full  <= count_nxt[FIFO_AW];
      tx_empty <= (count_nxt == '0);
      overflow <= overflow | (wr_vld & count[FIFO_AW] & ~pop);
    end
  end

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d, busy_d;
  logic          baud_end, has_data;
  logic [7:0]    head;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign head     = mem[rptr];
  assign has_data = (count != '0);
  assign baud_end = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx;
    busy_d  = tx_busy;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (has_data) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: if (baud_end) begin
        baud_d  = '0;
        tx_d    = shift_q[0];
        state_d = DATA;
      end
      DATA: if (baud_end) begin
        baud_d = '0;
        if (bit_q == 3'd7) begin
          bit_d = '0;
`ifdef UART_TX_PARITY_EN
          tx_d    = par_q;
          state_d = PARITY;
`else
          tx_d    = 1'b1;
          state_d = STOP;
`endif
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
          tx_d    = shift_q[1];
          bit_d   = bit_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_end) begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = STOP;
      end
`endif
      STOP: if (baud_end) begin
        baud_d = '0;
        // back-to-back: next start bit follows the stop bit with no idle gap
        if (has_data) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end else begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps plus random strobes, every cycle compared
// against a frame-position model built from a byte queue and a cycle countdown.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       i_clk   = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] wr_data = '0;
  logic       io_load = 1'b1;
  logic       tx, tx_full, tx_empty, tx_busy, overflow;

  int total = 0;
  int bad   = 0;
  int busy_cnt = 0;

  logic [7:0] q[$];
  logic       m_pend, m_ld, m_ovf;
  logic [7:0] m_pdata, m_cur;
  int         m_left;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .i_clk(i_clk), .reset(reset), .wr_data(wr_data), .io_load(io_load),
    .tx(tx), .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .overflow(overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_pend  = 1'b0;
    m_pdata = '0;
    m_ld    = 1'b1;
    m_ovf   = 1'b0;
    m_left  = 0;
    m_cur   = '0;
  endtask

  // One rising edge of the model: transmitter pop, then the pending push, then strobe detection.
  task automatic m_edge();
    bit do_pop;
    if (!reset) return;
    do_pop = (m_left <= 1) && (q.size() > 0);
    if (m_left > 0) m_left--;
    if (do_pop) begin
      m_cur  = q.pop_front();
      m_left = FRAME;
    end
    if (m_pend) begin
      if (q.size() < DEPTH) q.push_back(m_pdata);
      else m_ovf = 1'b1;
    end
    m_pend  = m_ld && !io_load;
    m_pdata = wr_data;
    m_ld    = io_load;
  endtask

  function automatic logic exp_tx();
    int b;
    if (m_left == 0) return 1'b1;
    b = (FRAME - m_left) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  task automatic check_all();
    chk("tx", tx, exp_tx());
    chk("tx_busy", tx_busy, m_left > 0);
    chk("tx_empty", tx_empty, q.size() == 0);
    chk("tx_full", tx_full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic tick();
    @(posedge i_clk);
    m_edge();
    #1;
    check_all();
    if (tx_busy === 1'b1) busy_cnt++;
  endtask

  task automatic pulse(input logic [7:0] d);
    wr_data = d;
    io_load = 1'b0;
    tick();
    io_load = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_reset();
    check_all();
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic bit9_case(input logic [7:0] d, input logic e);
    int b0;
    pulse(d);
    b0 = busy_cnt;
    tick();
    repeat (9 * CPB + 1) tick();
    chk("bit9_value", tx, e);
    repeat (FRAME) tick();
    chk("frame_len", busy_cnt - b0, FRAME);
  endtask

  initial begin
    int b0;
    m_reset();
    repeat (3) tick();
    chk("rst_tx", tx, 1);
    chk("rst_empty", tx_empty, 1);
    chk("rst_busy", tx_busy, 0);
    reset = 1'b1;
    tick();

    // 1: single byte, latency and frame length
    b0 = busy_cnt;
    pulse(8'h41);
    chk("t1_empty_fall", tx_empty, 0);
    repeat (FRAME + 6) tick();
    chk("t1_busy_len", busy_cnt - b0, FRAME);
    chk("t1_empty_end", tx_empty, 1);
    chk("t1_tx_idle", tx, 1);

    // 2: strobe held low writes once
    b0 = busy_cnt;
    wr_data = 8'h55;
    io_load = 1'b0;
    repeat (10) tick();
    io_load = 1'b1;
    repeat (2 * FRAME) tick();
    chk("t2_one_frame", busy_cnt - b0, FRAME);

    // 3: fill while sending, sixth write dropped
    b0 = busy_cnt;
    for (int d = 1; d <= 6; d++) pulse(8'(d));
    chk("t3_full", tx_full, 1);
    chk("t3_overflow", overflow, 1);
    repeat (6 * FRAME) tick();
    chk("t3_five_frames", busy_cnt - b0, 5 * FRAME);

    // 4: write lands on the pop edge while full
    do_reset();
    for (int i = 0; i < 5; i++) pulse(8'($urandom));
    chk("t4_full", tx_full, 1);
    for (int i = 0; i < 2 * FRAME && m_left != 2; i++) tick();
    chk("t4_align", m_left, 2);
    wr_data = 8'hC3;
    io_load = 1'b0;
    tick();
    io_load = 1'b1;
    tick();
    chk("t4_still_full", tx_full, 1);
    chk("t4_no_overflow", overflow, 0);
    repeat (5 * FRAME + 10) tick();
    chk("t4_drained", tx_empty, 1);

    // 5: asynchronous reset mid-DATA
    do_reset();
    pulse(8'hA5);
    repeat (3 * CPB + 2) tick();
    chk("t5_busy_before", tx_busy, 1);
    reset = 1'b0;
    #1;
    m_reset();
    chk("t5_tx", tx, 1);
    chk("t5_busy", tx_busy, 0);
    chk("t5_empty", tx_empty, 1);
    repeat (2) tick();
    reset = 1'b1;
    b0 = busy_cnt;
    repeat (FRAME + 10) tick();
    chk("t5_no_residual", busy_cnt - b0, 0);

    // random strobes: sparse, then dense enough to overflow
    do_reset();
    for (int i = 0; i < 800; i++) begin
      io_load = ($urandom_range(0, 39) != 0);
      wr_data = 8'($urandom);
      tick();
    end
    for (int i = 0; i < 800; i++) begin
      io_load = ($urandom_range(0, 3) != 0);
      wr_data = 8'($urandom);
      tick();
    end
    io_load = 1'b1;
    repeat ((DEPTH + 2) * FRAME) tick();
    chk("rand_drained", tx_empty, 1);

    // 6: parity bit (or stop bit in the 8N1 build) and frame length
    do_reset();
`ifdef UART_TX_PARITY_EN
    bit9_case(8'h07, 1'b1);
    bit9_case(8'h03, 1'b0);
`else
    bit9_case(8'h07, 1'b1);
    bit9_case(8'h03, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Downstream consumer of the CPU's I/O store path: captures bytes written when the active-low IOload strobe falls, buffers them in a FIFO, and serialises them on a TX line.
- Frame format is 8N1, LSB first.
- Exposes `tx_full` and `tx_empty` as active-high status lines. These are intended to drive the two spare jump-logic inputs currently tied low, so programs can poll the UART with conditional jumps.

Parameters:
- CLKS_PER_BIT, 16, i_clk cycles per serial bit (must be >= 2).
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries (16).

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_data  input  8  data bus value to be transmitted.
- io_load  input  1  active-low write strobe (IOload); a falling edge requests a write.
- tx  output  1  serial output; idle high.
- tx_full  output  1  high when the FIFO holds 2**FIFO_AW entries.
- tx_empty  output  1  high when the FIFO holds 0 entries.
- tx_busy  output  1  high while a frame is being shifted out.
- overflow  output  1  sticky; set when a write is dropped because the FIFO is full.

Behaviour:

Reset:
- Asserting reset low asynchronously forces, regardless of in-flight activity:
  - outputs: tx=1, tx_full=0, tx_empty=1, tx_busy=0, overflow=0;
  - internal state: FIFO pointers and count=0, bit counter=0, baud counter=0, state=IDLE, io_load history register=1.
- A frame that is partially sent is abandoned; tx returns high immediately.
- The history register resets to 1, so io_load held low through reset release does not generate a write.

Write capture:
- io_load is sampled each rising edge into `ld_q`.
- A write event occurs on the edge where `ld_q`=1 and `io_load`=0. It is a single-cycle event, so a strobe held low many cycles writes exactly once.
- `wr_data` is sampled on that same edge.
- Latency: the byte is in the FIFO, and `tx_empty` drops, one cycle after the sampling edge.

FIFO:
- Circular buffer with FIFO_AW-bit read and write pointers that wrap modulo depth.
- Count is FIFO_AW+1 bits wide.
- A write is accepted if count < depth, OR if a pop occurs on the same edge.
- A write to a full FIFO with no simultaneous pop is dropped, and `overflow` is set to 1 and held until reset.
- Simultaneous push and pop leaves count unchanged.
- `tx_full` and `tx_empty` are registered, decoded from the next count value.

Transmit FSM (states IDLE, START, DATA, STOP); each non-IDLE state lasts CLKS_PER_BIT cycles:
- IDLE: if count>0, pop the head into the shift register, set tx=0 and tx_busy=1, and enter START. Otherwise tx=1 and tx_busy=0.
- START: tx=0 for the bit time, then tx=shift[0] and enter DATA.
- DATA: each bit time, shift right and increment the bit counter. After bit 7 completes, tx=1 and enter STOP.
- STOP: tx=1 for one bit time. At the end of STOP:
  - if count>0, pop and go directly to START (back-to-back frames, no idle gap);
  - otherwise go to IDLE with tx_busy=0.
- Pop timing: a byte written while the FIFO is empty and the FSM is in IDLE appears as a start bit two cycles after the sampling edge.
- Frame length: exactly 10*CLKS_PER_BIT cycles per byte.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - a PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for one bit time;
  - the frame is 8E1, 11*CLKS_PER_BIT cycles.
- When undefined: the PARITY state and its logic are absent; the frame is 8N1, 10*CLKS_PER_BIT cycles.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2 unless stated):
1. Reset, pulse io_load low 1 cycle with wr_data=0x41 -> `tx_empty` falls next cycle. tx then reads, LSB first, 4 cycles per bit:
   - 0 (start);
   - data 1,0,0,0,0,0,1,0;
   - 1 (stop).
   Total 40 cycles; `tx_busy` is high throughout, then low; `tx_empty`=1.
2. Hold io_load low 10 cycles with wr_data=0x55 -> exactly one byte is transmitted.
3. Write 0x01..0x05 on consecutive falling strobes while the first frame is in flight:
   - `tx_full` asserts at 4 entries, after one has been popped;
   - the 6th write is dropped and `overflow`=1;
   - `tx` emits 0x01..0x05 back-to-back with no gap between stop and start bits.
4. Pop and write on the same edge while full -> count stays at 4, write accepted, `overflow` stays 0.
5. Assert reset mid-DATA of byte 0xA5 -> `tx`=1, `tx_busy`=0, `tx_empty`=1 immediately. After release, no residual bits are sent.
6. With UART_TX_PARITY_EN, wr_data=0x07 -> parity bit = 1; frame is 44 cycles. wr_data=0x03 -> parity bit = 0.
